fp_div_seq: RTL and testbench

- Multicycle IEEE-754 single-precision divider: result = a / b. The inverse of the team's combinational fp multiplier.
- Sits beside the FP multiplier in the multicycle datapath. The control FSM issues `start` and stalls until `done`.
- Mantissa quotient is produced by a bit-serial restoring division, one quotient bit per clock.
- No NaN/Inf generation. Denormal inputs are treated as zero.

---
 rtl/fp_pkg.sv | 35 +++
 rtl/fp_div_mant.sv | 63 ++++++
 rtl/fp_div_seq.sv | 165 ++++++++++++++++
 tb/tb_fp_div_seq.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared floating-point definitions for the multicycle FP datapath.
// Field widths, saturation constant, divider FSM states, field helpers.
package fp_pkg;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int BIAS  = 127;

  localparam logic [30:0] MAX_FINITE = 31'h7F7FFFFF;

  typedef enum logic [1:0] {
    IDLE,
    DIVIDE,
    NORM,
    DONE
  } div_state_e;

  function automatic logic fp_sign(input logic [31:0] x);
    return x[31];
  endfunction

  function automatic logic [EXP_W-1:0] fp_exp(input logic [31:0] x);
    return x[30:23];
  endfunction

  function automatic logic [MAN_W-1:0] fp_frac(input logic [31:0] x);
    return x[MAN_W-1:0];
  endfunction

  // Significand with hidden bit; denormals read as zero.
  function automatic logic [MAN_W:0] fp_mant(input logic [31:0] x);
    return {(fp_exp(x) != '0), fp_frac(x)};
  endfunction

endpackage

// File: rtl/fp_div_mant.sv
// Bit-serial restoring divider for 24-bit significands.
// Produces q = floor(ma * 2^25 / mb), one bit per step, MSB first.
module fp_div_mant
  import fp_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         step,
  input  logic [MAN_W:0] ma,
  input  logic [MAN_W:0] mb,
  output logic [25:0]  q,
  output logic         rem_nz,
  output logic         last
);

  logic [MAN_W+1:0] rem_q, rem_d;
  logic [MAN_W:0]   mb_q, mb_d;
  logic [25:0]      q_q, q_d;
  logic [4:0]       cnt_q, cnt_d;
  logic             ge;
  logic [MAN_W+1:0] diff;

  // One restoring step: subtract if it fits, then shift.
  always_comb begin
    rem_d = rem_q;
    mb_d  = mb_q;
    q_d   = q_q;
    cnt_d = cnt_q;
    ge    = rem_q >= {1'b0, mb_q};
    diff  = ge ? rem_q - {1'b0, mb_q} : rem_q;
    if (load) begin
      rem_d = {1'b0, ma};
      mb_d  = mb;
      q_d   = '0;
      cnt_d = 5'd25;
    end else if (step) begin
      rem_d = {diff[MAN_W:0], 1'b0};
      q_d   = {q_q[24:0], ge};
      cnt_d = cnt_q - 5'd1;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      rem_q <= '0;
      mb_q  <= '0;
      q_q   <= '0;
      cnt_q <= '0;
    end else begin
      rem_q <= rem_d;
      mb_q  <= mb_d;
      q_q   <= q_d;
      cnt_q <= cnt_d;
    end
  end

  assign q      = q_q;
  assign rem_nz = |rem_q;
  assign last   = cnt_q == 5'd0;

endmodule

// File: rtl/fp_div_seq.sv
// Multicycle single-precision divider, result = a / b, 28-clock latency.
// Optional FP_DIV_RNE_EN selects round-to-nearest-even (default truncate).
module fp_div_seq
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        dz,
  output logic        of,
  output logic        uf
);

  div_state_e state_q, state_d;

  logic             sign_q, sign_d;
  logic [EXP_W-1:0] ea_q, ea_d;
  logic [EXP_W-1:0] eb_q, eb_d;
  logic [31:0]      result_q, result_d;
  logic             dz_q, dz_d;
  logic             of_q, of_d;
  logic             uf_q, uf_d;
  logic             done_q, done_d;

  logic             accept;
  logic             step;
  logic             last;
  logic             rem_nz;
  logic [25:0]      q;

  logic signed [9:0] e_n, e_r;
  logic [MAN_W-1:0]  frac_n, frac_r;

  // The done cycle blocks a new accept so the pulse stays isolated.
  assign accept = (state_q == IDLE) && start && !done_q;
  assign step   = state_q == DIVIDE;

  fp_div_mant u_mant (
    .clk    (clk),
    .reset  (reset),
    .load   (accept),
    .step   (step),
    .ma     (fp_mant(a)),
    .mb     (fp_mant(b)),
    .q      (q),
    .rem_nz (rem_nz),
    .last   (last)
  );

  // Control FSM next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = DIVIDE;
      DIVIDE:  if (last) state_d = NORM;
      NORM:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Normalise quotient to 1.f and form the biased exponent.
  always_comb begin
    frac_n = q[25] ? q[24:2] : q[23:1];
    e_n    = {2'b00, ea_q} - {2'b00, eb_q}
           + (q[25] ? 10'(BIAS) : 10'(BIAS - 1));
  end

`ifdef FP_DIV_RNE_EN
  logic guard, sticky, inc, carry;

  // Round to nearest even; a mantissa carry bumps the exponent.
  always_comb begin
    guard  = q[25] ? q[1] : q[0];
    sticky = rem_nz | (q[25] & q[0]);
    inc    = guard & (sticky | frac_n[0]);
    {carry, frac_r} = {1'b0, frac_n} + {{MAN_W{1'b0}}, inc};
    e_r    = carry ? e_n + 10'sd1 : e_n;
  end
`else
  logic unused_rnd;

  // Truncation: guard and sticky are dropped.
  always_comb begin
    frac_r = frac_n;
    e_r    = e_n;
  end

  assign unused_rnd = q[0] ^ rem_nz;
`endif

  // Operand capture and result/flag formation.
  always_comb begin
    sign_d   = sign_q;
    ea_d     = ea_q;
    eb_d     = eb_q;
    result_d = result_q;
    dz_d     = dz_q;
    of_d     = of_q;
    uf_d     = uf_q;
    done_d   = state_q == DONE;
    if (accept) begin
      sign_d = fp_sign(a) ^ fp_sign(b);
      ea_d   = fp_exp(a);
      eb_d   = fp_exp(b);
    end
    if (state_q == NORM) begin
      dz_d = 1'b0;
      of_d = 1'b0;
      uf_d = 1'b0;
      if (eb_q == '0) begin
        dz_d     = 1'b1;
        result_d = {sign_q, MAX_FINITE};
      end else if (ea_q == '0) begin
        result_d = {sign_q, 31'h0};
      end else if (e_r >= 10'sd255) begin
        of_d     = 1'b1;
        result_d = {sign_q, MAX_FINITE};
      end else if (e_r <= 10'sd0) begin
        uf_d     = 1'b1;
        result_d = {sign_q, 31'h0};
      end else begin
        result_d = {sign_q, e_r[EXP_W-1:0], frac_r};
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      sign_q   <= 1'b0;
      ea_q     <= '0;
      eb_q     <= '0;
      result_q <= '0;
      dz_q     <= 1'b0;
      of_q     <= 1'b0;
      uf_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sign_q   <= sign_d;
      ea_q     <= ea_d;
      eb_q     <= eb_d;
      result_q <= result_d;
      dz_q     <= dz_d;
      of_q     <= of_d;
      uf_q     <= uf_d;
      done_q   <= done_d;
    end
  end

  assign busy   = (state_q != IDLE) || done_q;
  assign done   = done_q;
  assign result = result_q;
  assign dz     = dz_q;
  assign of     = of_q;
  assign uf     = uf_q;

endmodule

// File: tb/tb_fp_div_seq.sv
// Self-checking bench for fp_div_seq.
// Integer-division reference model plus directed literal vectors.
module tb_fp_div_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] a, b;
  logic        busy, done, dz, of, uf;
  logic [31:0] result;

  int n_cmp = 0;
  int n_bad = 0;

  logic        exp_valid = 1'b0;
  logic [31:0] exp_res;
  logic        exp_dz, exp_of, exp_uf;

`ifdef FP_DIV_RNE_EN
  localparam logic [31:0] ONE_THIRD = 32'h3EAAAAAB;
  localparam logic [31:0] TWO_THIRD = 32'h3F2AAAAB;
`else
  localparam logic [31:0] ONE_THIRD = 32'h3EAAAAAA;
  localparam logic [31:0] TWO_THIRD = 32'h3F2AAAAA;
`endif

  fp_div_seq dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .dz     (dz),
    .of     (of),
    .uf     (uf)
  );

  always #5 clk = ~clk;

  // Reference: exact quotient of the significands by integer division.
  function automatic logic [34:0] model(input logic [31:0] x,
                                        input logic [31:0] y);
    logic        s, fdz, fof, fuf;
    int          ea, eb, e;
    longint      ma, mb, num, quot;
    logic [31:0] r;
`ifdef FP_DIV_RNE_EN
    longint      rest;
`endif
    s   = x[31] ^ y[31];
    ea  = int'(x[30:23]);
    eb  = int'(y[30:23]);
    fdz = 1'b0;
    fof = 1'b0;
    fuf = 1'b0;
    if (eb == 0) begin
      fdz = 1'b1;
      r   = {s, 31'h7F7FFFFF};
    end else if (ea == 0) begin
      r = {s, 31'h0};
    end else begin
      ma = longint'({1'b1, x[22:0]});
      mb = longint'({1'b1, y[22:0]});
      if (ma >= mb) begin
        num = ma << 23;
        e   = ea - eb + 127;
      end else begin
        num = ma << 24;
        e   = ea - eb + 126;
      end
      quot = num / mb;
`ifdef FP_DIV_RNE_EN
      rest = num % mb;
      if (2 * rest > mb || (2 * rest == mb && quot[0]))
        quot = quot + 1;
      if (quot == (longint'(1) << 24)) begin
        quot = longint'(1) << 23;
        e    = e + 1;
      end
`endif
      if (e >= 255) begin
        fof = 1'b1;
        r   = {s, 31'h7F7FFFFF};
      end else if (e <= 0) begin
        fuf = 1'b1;
        r   = {s, 31'h0};
      end else begin
        r = {s, e[7:0], quot[22:0]};
      end
    end
    return {r, fdz, fof, fuf};
  endfunction

  // Every done pulse is checked against the model's pending answer.
  initial begin
    forever begin
      @(negedge clk);
      if (done) begin
        n_cmp++;
        if (!exp_valid) begin
          n_bad++;
          $display("FAIL unexpected_done: got result %08h, required no done",
                   result);
        end else if ({result, dz, of, uf} !==
                     {exp_res, exp_dz, exp_of, exp_uf}) begin
          n_bad++;
          $display("FAIL model_cmp: got %08h dz%b of%b uf%b, required %08h dz%b of%b uf%b",
                   result, dz, of, uf, exp_res, exp_dz, exp_of, exp_uf);
        end
        exp_valid = 1'b0;
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endtask

  task automatic set_model(input logic [31:0] x, input logic [31:0] y);
    {exp_res, exp_dz, exp_of, exp_uf} = model(x, y);
    exp_valid = 1'b1;
  endtask

  // Returns #1 after the edge that accepts the request.
  task automatic issue(input logic [31:0] x, input logic [31:0] y);
    @(posedge clk);
    #1;
    a     = x;
    b     = y;
    start = 1'b1;
    set_model(x, y);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Counts edges until done, with a bounded budget.
  task automatic wait_done(output int lat, output logic busy_ok);
    logic got;
    got     = 1'b0;
    lat     = 0;
    busy_ok = 1'b1;
    while (!got && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (!busy) busy_ok = 1'b0;
      if (done) got = 1'b1;
    end
  endtask

  task automatic op(input string nm, input logic [31:0] x,
                    input logic [31:0] y, input logic [31:0] hres,
                    input logic [2:0] hflags);
    int   lat;
    logic bok;
    issue(x, y);
    wait_done(lat, bok);
    chk({nm, "_res"}, 64'(result), 64'(hres));
    chk({nm, "_flags"}, 64'({dz, of, uf}), 64'(hflags));
    chk({nm, "_lat"}, 64'(lat), 64'd28);
    chk({nm, "_busy"}, 64'(bok), 64'd1);
  endtask

  initial begin
    int   lat;
    logic bok;
    reset = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_flags", 64'({dz, of, uf}), 64'd0);

    op("six_by_two", 32'h40C00000, 32'h40000000, 32'h40400000, 3'b000);
    op("sign", 32'hBFC00000, 32'h3F000000, 32'hC0400000, 3'b000);
    op("one_third", 32'h3F800000, 32'h40400000, ONE_THIRD, 3'b000);
    op("two_third", 32'h40000000, 32'h40400000, TWO_THIRD, 3'b000);
    op("one_by_one", 32'h3F800000, 32'h3F800000, 32'h3F800000, 3'b000);
    op("div_zero", 32'h3F800000, 32'h00000000, 32'h7F7FFFFF, 3'b100);
    op("neg_dz", 32'hC0000000, 32'h00000000, 32'hFF7FFFFF, 3'b100);
    op("overflow", 32'h7F000000, 32'h00800000, 32'h7F7FFFFF, 3'b010);
    op("underflow", 32'h00800000, 32'h7F000000, 32'h00000000, 3'b001);
    op("zero_num", 32'h80000000, 32'h3F800000, 32'h80000000, 3'b000);
    op("denorm_num", 32'h00400000, 32'h40000000, 32'h00000000, 3'b000);

    // Model-only vectors: pi/e and 10/7.
    issue(32'h40490FDB, 32'h402DF854);
    wait_done(lat, bok);
    issue(32'h41200000, 32'h40E00000);
    wait_done(lat, bok);

    // Start while busy must not restart or replace the operands.
    issue(32'h40C00000, 32'h40000000);
    repeat (5) @(posedge clk);
    #1;
    a     = 32'h3F800000;
    b     = 32'h40400000;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(lat, bok);
    chk("busy_start_res", 64'(result), 64'h40400000);
    chk("busy_start_lat", 64'(lat), 64'd22);

    // Start raised in the done cycle is only taken one cycle later.
    #1;
    a     = 32'h40000000;
    b     = 32'h40400000;
    start = 1'b1;
    set_model(32'h40000000, 32'h40400000);
    @(posedge clk);
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(lat, bok);
    chk("done_cycle_lat", 64'(lat), 64'd28);
    chk("done_cycle_res", 64'(result), 64'(TWO_THIRD));

    // Reset in the middle of DIVIDE aborts without a done.
    issue(32'h40C00000, 32'h40000000);
    repeat (10) @(posedge clk);
    #1;
    reset     = 1'b1;
    exp_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_result", 64'(result), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    repeat (35) @(posedge clk);

    op("after_abort", 32'hBFC00000, 32'h3F000000, 32'hC0400000, 3'b000);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
